// File: rtl/cnt_arbiter.sv
// cnt_arbiter: round-robin arbiter granting one requester at a time a LOAD/UP/DOWN/NOP
// burst on a shared counter. Define CNT_ARB_BOUNDARY_ABORT_EN to end bursts at the counter limits.
module cnt_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned WIDTH = 5,
    parameter int unsigned LEN_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [2*NREQ-1:0]     OP,
    input  logic [WIDTH*NREQ-1:0] DATA,
    input  logic [LEN_W*NREQ-1:0] LEN,
    output logic [NREQ-1:0]       GNT,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  BUSY,
    output logic                  CNT_LOAD,
    output logic                  CNT_UP,
    output logic                  CNT_DN,
    output logic [WIDTH-1:0]      CNT_IN,
    input  logic                  CNT_HIGH,
    input  logic                  CNT_LOW
);
    localparam int unsigned PTR_W = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DN   = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [1:0]       state_q, state_nxt;
    logic [PTR_W-1:0] ptr_q, ptr_nxt;
    logic [PTR_W-1:0] win_q, win_nxt;
    logic [LEN_W-1:0] rem_q, rem_nxt;
    logic             up_q, up_nxt;
    logic             dn_q, dn_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic             done_nxt, err_nxt, busy_nxt, load_nxt;
    logic [WIDTH-1:0] cnt_in_nxt;
    logic             abort_c;

    logic [PTR_W-1:0] win_c;
    logic [PTR_W-1:0] cand_idx;
    logic             found_c;
    int unsigned      cand_c;
    logic [1:0]       op_c;
    logic [WIDTH-1:0] data_c;
    logic [LEN_W-1:0] len_c;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        win_c    = '0;
        found_c  = 1'b0;
        cand_c   = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = 32'(ptr_q) + k;
            if (cand_c >= NREQ) begin
                cand_c = cand_c - NREQ;
            end
            cand_idx = PTR_W'(cand_c);
            if (!found_c && REQ[cand_idx]) begin
                found_c = 1'b1;
                win_c   = cand_idx;
            end
        end
    end

    // Winner's request fields.
    always_comb begin
        op_c   = '0;
        data_c = '0;
        len_c  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (PTR_W'(k) == win_c) begin
                op_c   = OP[2*k +: 2];
                data_c = DATA[WIDTH*k +: WIDTH];
                len_c  = LEN[LEN_W*k +: LEN_W];
            end
        end
    end

`ifdef CNT_ARB_BOUNDARY_ABORT_EN
    // The counter flags describe the current cycle, so masking has to be combinational.
    assign abort_c = (up_q & CNT_HIGH) | (dn_q & CNT_LOW);
    assign CNT_UP  = up_q & ~CNT_HIGH;
    assign CNT_DN  = dn_q & ~CNT_LOW;
`else
    logic unused_bound;
    assign unused_bound = CNT_HIGH ^ CNT_LOW;
    assign abort_c      = 1'b0;
    assign CNT_UP       = up_q;
    assign CNT_DN       = dn_q;
`endif

    always_comb begin
        state_nxt  = state_q;
        ptr_nxt    = ptr_q;
        win_nxt    = win_q;
        rem_nxt    = rem_q;
        gnt_nxt    = GNT;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        load_nxt   = 1'b0;
        up_nxt     = 1'b0;
        dn_nxt     = 1'b0;
        cnt_in_nxt = '0;
        case (state_q)
            S_IDLE: begin
                gnt_nxt = '0;
                rem_nxt = '0;
                if (found_c) begin
                    state_nxt = S_RUN;
                    win_nxt   = win_c;
                    gnt_nxt   = NREQ'(1) << win_c;
                    case (op_c)
                        OP_LOAD: begin
                            load_nxt   = 1'b1;
                            cnt_in_nxt = data_c;
                        end
                        OP_UP: begin
                            up_nxt  = 1'b1;
                            rem_nxt = len_c;
                        end
                        OP_DN: begin
                            dn_nxt  = 1'b1;
                            rem_nxt = len_c;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (abort_c) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    rem_nxt   = '0;
                end else if (rem_q == '0) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    up_nxt  = up_q;
                    dn_nxt  = dn_q;
                    rem_nxt = rem_q - LEN_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                ptr_nxt   = win_q;
                gnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                rem_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            ptr_q    <= PTR_W'(NREQ - 1);
            win_q    <= '0;
            rem_q    <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            GNT      <= '0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            BUSY     <= 1'b0;
            CNT_LOAD <= 1'b0;
            CNT_IN   <= '0;
        end else begin
            state_q  <= state_nxt;
            ptr_q    <= ptr_nxt;
            win_q    <= win_nxt;
            rem_q    <= rem_nxt;
            up_q     <= up_nxt;
            dn_q     <= dn_nxt;
            GNT      <= gnt_nxt;
            DONE     <= done_nxt;
            ERR      <= err_nxt;
            BUSY     <= busy_nxt;
            CNT_LOAD <= load_nxt;
            CNT_IN   <= cnt_in_nxt;
        end
    end
endmodule
